fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the RISC-V core; sits directly upstream of the controller/decoder. It owns the program counter, issues word fetches to instruction memory over a req/ack handshake with one outstanding request, buffers returned words in a small FIFO, and presents {instruction, pc, pc+4} with a valid/ready handshake. The controller's `pc_src` and the datapath's branch/jump target drive the redirect input, which flushes in-flight work.

## Interface
- `XLEN`, 32: address and data width.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `DEPTH`, 2: instruction FIFO entries (power of two, ≥2).

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  XLEN  word-aligned fetch address.
- `imem_ack`  in  1  request complete; `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `redirect`  in  1  `pc_src` from the controller.
- `redirect_pc`  in  XLEN  branch/jump target.
- `inst_valid`  out  1  FIFO head valid.
- `inst_ready`  in  1  consumer accepts head.
- `inst`  out  32  head instruction.
- `inst_pc`  out  XLEN  head PC.
- `inst_pc_plus4`  out  XLEN  head PC + 4.
- `op`  out  7  `inst[6:0]`.
- `funct3`  out  3  `inst[14:12]`.
- `funct7b5`  out  1  `inst[30]`.

## Operation
- FSM: IDLE (no request), REQ (request outstanding), DROP (outstanding request orphaned by redirect; its ack is discarded).
- `fetch_pc` register: address of the next request; increments by 4 on each accepted ack.
- Issue when `occupancy + outstanding < DEPTH`, counting a same-cycle pop as freeing a slot. IDLE→REQ on issue; REQ stays in REQ on ack if issue is still allowed, otherwise returns to IDLE.
- `imem_req` is high in REQ and DROP; `imem_addr` stays stable from assertion until ack.
- On ack in REQ: push {rdata, fetch_pc} and set `fetch_pc += 4`.
- Redirect:
  - Flush the FIFO.
  - Set `fetch_pc` to `{redirect_pc[XLEN-1:2], 2'b00}`; misaligned targets are silently aligned.
  - Request outstanding and no ack this cycle → DROP. In DROP, the ack is discarded and the FSM goes straight to REQ at the new `fetch_pc`.
  - Ack arriving in the redirect cycle → data discarded, next state REQ at the new PC.
- Redirect in the same cycle as a head pop: the pop counts as accepted, because the redirecting instruction is the head. The flush removes all remaining entries.
- Redirect while in DROP: update `fetch_pc` and remain in DROP.
- Outputs are driven from the FIFO head. When `inst_valid` is 0, `inst` = 32'h0000_0013 (NOP) and the other head fields are 0.
- `inst_pc_plus4` wraps modulo 2^XLEN.

## Timing
- Reset values:
  - `imem_req` = 0, `imem_addr` = `RESET_PC`.
  - `inst_valid` = 0, `inst` = NOP, `inst_pc` = 0, `inst_pc_plus4` = 0.
  - FSM = IDLE, FIFO empty.
- First `imem_req` appears in the first cycle after reset release.
- Ack may arrive in the same cycle as req (zero-wait memory); the ack is sampled at the clock edge.
- Fill latency: ack edge → `inst_valid` = 1 in the next cycle. There is no combinational path from `imem_rdata` to `inst`.
- Zero-wait memory with `inst_ready` held at 1 sustains one instruction per cycle.
- Redirect → first request at the new PC: the next cycle, or one cycle after the orphaned ack.
- Asserting `rst_n` mid-request abandons the request asynchronously; instruction memory must tolerate a dropped req.

## Structure
- Shared package `rv_pkg`: `XLEN`, `NOP_INST`, opcode field slice positions, and the FSM state enum `fetch_state_t`.
- Sub-module `fetch_fifo`: synchronous FIFO of {inst, pc} with DEPTH entries, a flush input, and registered head. It supports push and pop in the same cycle when full.

## Test plan
- Reset release with RESET_PC = 0x100 and zero-wait memory returning addr^0xA5 → `imem_addr` 0x100, 0x104, 0x108 on consecutive cycles; `inst_valid` from cycle 2; `inst_pc_plus4` = `inst_pc` + 4.
- `inst_ready` = 0 for 5 cycles → exactly DEPTH entries buffered, then `imem_req` low. Releasing ready drains them in order, and fetching resumes at 0x100 + 4·DEPTH.
- Ack after 3 cycles with redirect to 0x200 in wait cycle 1 → orphaned word not delivered; next request at 0x200; first valid `inst_pc` = 0x200.
- Redirect coinciding with an ack and a head pop → popped instruction counted once, acked word dropped, FIFO empty, next `imem_addr` = target.
- Redirect to 0x303 → `imem_addr` = 0x300.
- `rst_n` pulsed low while in REQ → outputs return to reset values immediately; refetch starts at RESET_PC.

Source files
------------

// File: rtl/rv_pkg.sv
// +------------------------------------------------------------------+
// | rv_pkg : shared constants and types for the RISC-V front end     |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package rv_pkg;

   localparam int XLEN = 32;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   localparam int OP_LSB   = 0;
   localparam int OP_MSB   = 6;
   localparam int F3_LSB   = 12;
   localparam int F3_MSB   = 14;
   localparam int F7B5_BIT = 30;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_DROP = 2'd2;

   typedef enum logic [1:0] {
      FS_IDLE = S_IDLE,
      FS_REQ  = S_REQ,
      FS_DROP = S_DROP
   } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// +------------------------------------------------------------------+
// | fetch_fifo : {inst, pc} FIFO with flush and registered head      |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module fetch_fifo #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2,
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            push,
   input  logic [31:0]     push_inst,
   input  logic [XLEN-1:0] push_pc,
   input  logic            pop,
   output logic            head_valid,
   output logic [31:0]     head_inst,
   output logic [XLEN-1:0] head_pc,
   output logic [CW-1:0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [31:0]     inst_mem [DEPTH];
   logic [XLEN-1:0] pc_mem   [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   assign do_pop  = pop && (count != '0);
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push = push && ((count < DEPTH_C) || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         inst_mem[wr_ptr] <= push_inst;
         pc_mem[wr_ptr]   <= push_pc;
      end
   end

   assign head_valid = (count != '0);
   assign head_inst  = inst_mem[rd_ptr];
   assign head_pc    = pc_mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// +------------------------------------------------------------------+
// | fetch_unit : PC owner, imem req/ack fetcher and instruction FIFO |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module fetch_unit #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              DEPTH    = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [31:0]     inst,
   output logic [XLEN-1:0] inst_pc,
   output logic [XLEN-1:0] inst_pc_plus4,
   output logic [6:0]      op,
   output logic [2:0]      funct3,
   output logic            funct7b5
);

   import rv_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   fetch_state_t    state;
   fetch_state_t    state_next;
   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] pc_next;
   logic [XLEN-1:0] req_addr;
   logic [XLEN-1:0] target;
   logic [CW-1:0]   count;
   logic [CW-1:0]   occ_next;
   logic            pop;
   logic            push;
   logic            may_issue;
   logic            head_valid;
   logic [31:0]     head_inst;
   logic [XLEN-1:0] head_pc;

   assign target    = redirect_pc & ~XLEN'(3);
   assign pop       = head_valid & inst_ready;
   assign push      = (state == FS_REQ) & imem_ack & ~redirect;
   // Occupancy once this edge's pop/push land, with no request left outstanding.
   assign occ_next  = count - CW'(pop) + CW'(push);
   assign may_issue = (occ_next < DEPTH_C);

   always_comb begin
      state_next = state;
      pc_next    = fetch_pc;
      unique case (state)
         FS_IDLE: begin
            if (redirect) begin
               pc_next    = target;
               state_next = FS_REQ;
            end else if (may_issue) begin
               state_next = FS_REQ;
            end
         end
         FS_REQ: begin
            if (redirect) begin
               pc_next    = target;
               state_next = imem_ack ? FS_REQ : FS_DROP;
            end else if (imem_ack) begin
               pc_next    = fetch_pc + XLEN'(4);
               state_next = may_issue ? FS_REQ : FS_IDLE;
            end
         end
         FS_DROP: begin
            if (redirect) pc_next = target;
            if (imem_ack) state_next = FS_REQ;
         end
         default: state_next = FS_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= FS_IDLE;
         fetch_pc <= RESET_PC;
         req_addr <= RESET_PC;
      end else begin
         state    <= state_next;
         fetch_pc <= pc_next;
         // The bus address is frozen while a request (even an orphaned one) waits for ack.
         if (!(imem_req && !imem_ack)) req_addr <= pc_next;
      end
   end

   assign imem_req  = (state != FS_IDLE);
   assign imem_addr = req_addr;

   fetch_fifo #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (redirect),
      .push       (push),
      .push_inst  (imem_rdata),
      .push_pc    (fetch_pc),
      .pop        (pop),
      .head_valid (head_valid),
      .head_inst  (head_inst),
      .head_pc    (head_pc),
      .count      (count)
   );

   assign inst_valid    = head_valid;
   assign inst          = head_valid ? head_inst : NOP_INST;
   assign inst_pc       = head_valid ? head_pc : '0;
   assign inst_pc_plus4 = head_valid ? (head_pc + XLEN'(4)) : '0;
   assign op            = inst[OP_MSB:OP_LSB];
   assign funct3        = inst[F3_MSB:F3_LSB];
   assign funct7b5      = inst[F7B5_BIT];

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// +------------------------------------------------------------------+
// | tb_fetch_unit : directed self-checking bench for fetch_unit      |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic [31:0] inst_pc_plus4;
   logic [6:0]  op;
   logic [2:0]  funct3;
   logic        funct7b5;

   int errors = 0;
   int checks = 0;
   int lat    = 0;
   int wait_cnt;

   always #5 clk = ~clk;

   fetch_unit #(
      .XLEN     (32),
      .RESET_PC (32'h0000_0100),
      .DEPTH    (2)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .redirect      (redirect),
      .redirect_pc   (redirect_pc),
      .inst_valid    (inst_valid),
      .inst_ready    (inst_ready),
      .inst          (inst),
      .inst_pc       (inst_pc),
      .inst_pc_plus4 (inst_pc_plus4),
      .op            (op),
      .funct3        (funct3),
      .funct7b5      (funct7b5)
   );

   // Instruction memory: acks after lat wait cycles, data = addr ^ 0xA5.
   always @(posedge clk) begin
      if (!imem_req || imem_ack) wait_cnt <= 0;
      else                       wait_cnt <= wait_cnt + 1;
   end
   always_comb begin
      imem_ack   = imem_req && (wait_cnt >= lat);
      imem_rdata = imem_addr ^ 32'h0000_00A5;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      inst_ready  = 1'b0;
      wait_cnt    = 0;
      tick();

      check("rst_req",   64'(imem_req),      64'h0);
      check("rst_addr",  64'(imem_addr),     64'h100);
      check("rst_valid", 64'(inst_valid),    64'h0);
      check("rst_inst",  64'(inst),          64'h13);
      check("rst_pc",    64'(inst_pc),       64'h0);
      check("rst_pc4",   64'(inst_pc_plus4), 64'h0);

      // Zero-wait stream from RESET_PC
      inst_ready = 1'b1;
      lat        = 0;
      rst_n      = 1'b1;
      tick();
      check("a_req1",  64'(imem_req),  64'h1);
      check("a_addr1", 64'(imem_addr), 64'h100);
      tick();
      check("a_addr2",  64'(imem_addr),     64'h104);
      check("a_valid2", 64'(inst_valid),    64'h1);
      check("a_pc2",    64'(inst_pc),       64'h100);
      check("a_pc4_2",  64'(inst_pc_plus4), 64'h104);
      check("a_inst2",  64'(inst),          64'h1A5);
      tick();
      check("a_addr3", 64'(imem_addr), 64'h108);
      check("a_pc3",   64'(inst_pc),   64'h104);
      check("a_inst3", 64'(inst),      64'h1A1);

      // Redirect coinciding with ack and head pop
      redirect    = 1'b1;
      redirect_pc = 32'h4000_5000;
      tick();
      redirect = 1'b0;
      check("d_valid", 64'(inst_valid), 64'h0);
      check("d_addr",  64'(imem_addr),  64'h4000_5000);
      check("d_req",   64'(imem_req),   64'h1);
      tick();
      check("d_pc",    64'(inst_pc),       64'h4000_5000);
      check("d_inst",  64'(inst),          64'h4000_50A5);
      check("d_op",    64'(op),            64'h25);
      check("d_f3",    64'(funct3),        64'h5);
      check("d_f7b5",  64'(funct7b5),      64'h1);
      check("d_pc4",   64'(inst_pc_plus4), 64'h4000_5004);

      // Misaligned target and PC+4 wrap
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0303;
      tick();
      redirect = 1'b0;
      check("e_addr",  64'(imem_addr),  64'h300);
      check("e_valid", 64'(inst_valid), 64'h0);
      tick();
      check("e_pc",   64'(inst_pc), 64'h300);
      check("e_inst", 64'(inst),    64'h3A5);
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFE;
      tick();
      redirect = 1'b0;
      check("e_addr_top", 64'(imem_addr), 64'hFFFF_FFFC);
      tick();
      check("e_pc_top",   64'(inst_pc),       64'hFFFF_FFFC);
      check("e_pc4_wrap", 64'(inst_pc_plus4), 64'h0);
      check("e_inst_top", 64'(inst),          64'hFFFF_FF59);
      check("e_addr_wrap",64'(imem_addr),     64'h0);

      // Asynchronous reset while a request is live
      rst_n = 1'b0;
      #1;
      check("f_req",   64'(imem_req),   64'h0);
      check("f_addr",  64'(imem_addr),  64'h100);
      check("f_valid", 64'(inst_valid), 64'h0);
      check("f_inst",  64'(inst),       64'h13);
      check("f_pc",    64'(inst_pc),    64'h0);
      tick();
      rst_n = 1'b1;
      tick();
      check("f_req1",  64'(imem_req),  64'h1);
      check("f_addr1", 64'(imem_addr), 64'h100);

      // Consumer stall: exactly DEPTH entries buffered
      inst_ready = 1'b0;
      do_reset();
      tick();
      check("b_addr1", 64'(imem_addr), 64'h100);
      tick();
      check("b_addr2", 64'(imem_addr), 64'h104);
      tick();
      repeat (5) tick();
      check("b_req_idle", 64'(imem_req),   64'h0);
      check("b_valid",    64'(inst_valid), 64'h1);
      check("b_head",     64'(inst_pc),    64'h100);
      inst_ready = 1'b1;
      tick();
      check("b_drain1", 64'(inst_pc),   64'h104);
      check("b_resume", 64'(imem_req),  64'h1);
      check("b_raddr",  64'(imem_addr), 64'h108);
      tick();
      check("b_drain2", 64'(inst_pc), 64'h108);

      // Slow memory with redirect while waiting
      lat = 3;
      do_reset();
      tick();
      check("c_addr1", 64'(imem_addr), 64'h100);
      tick();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0200;
      tick();
      redirect = 1'b0;
      check("c_drop_req",  64'(imem_req),   64'h1);
      check("c_drop_addr", 64'(imem_addr),  64'h100);
      check("c_drop_val",  64'(inst_valid), 64'h0);
      tick();
      tick();
      check("c_new_addr", 64'(imem_addr),  64'h200);
      check("c_no_orph",  64'(inst_valid), 64'h0);
      for (int i = 0; i < 20 && !inst_valid; i++) tick();
      check("c_valid", 64'(inst_valid), 64'h1);
      check("c_pc",    64'(inst_pc),    64'h200);
      check("c_inst",  64'(inst),       64'h2A5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
